wrapper_chain: RTL and testbench

Parametrised multi-cell scan wrapper chain: the next generation of the single-cell input wrapper, generalised to WIDTH cells behind one serial path. All state is in one clock domain, with capture/shift/update done through clock enables rather than gated clocks. The chain sits between the TDR controller and a core's functional inputs. It adds shift-length checking, an intest freeze mode and a registered core-side output.

---
 rtl/wrapper_chain_if.sv | 35 +++
 rtl/wrapper_chain.sv | 91 +++++++++
 tb/tb_wrapper_chain.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wrapper_chain_if.sv
// rtl/wrapper_chain_if.sv - scan wrapper chain bus between TDR controller and chain (WRAPCHAIN_BYPASS_EN adds wrp_bypass)
interface wrapper_chain_if #(
   parameter int WIDTH = 8
);
   logic             TDR_EN;
   logic             TDR_CAPTURE;
   logic             TDR_SHIFT;
   logic             TDR_UPDATE;
   logic [1:0]       wrp_mode;
   logic             WSI;
   logic             WSO;
   logic [WIDTH-1:0] CFI;
   logic [WIDTH-1:0] CFO;
   logic             upd_valid;
   logic             shift_cnt_err;
`ifdef WRAPCHAIN_BYPASS_EN
   logic             wrp_bypass;
`endif

   modport master (
`ifdef WRAPCHAIN_BYPASS_EN
      output wrp_bypass,
`endif
      output TDR_EN, TDR_CAPTURE, TDR_SHIFT, TDR_UPDATE, wrp_mode, WSI, CFI,
      input  WSO, CFO, upd_valid, shift_cnt_err
   );

   modport slave (
`ifdef WRAPCHAIN_BYPASS_EN
      input  wrp_bypass,
`endif
      input  TDR_EN, TDR_CAPTURE, TDR_SHIFT, TDR_UPDATE, wrp_mode, WSI, CFI,
      output WSO, CFO, upd_valid, shift_cnt_err
   );
endinterface

// File: rtl/wrapper_chain.sv
// rtl/wrapper_chain.sv - WIDTH-cell scan wrapper chain with shift-length check; optional bypass bit via WRAPCHAIN_BYPASS_EN
module wrapper_chain #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] SAFE_VAL = '0
) (
   input logic            TDR_TCK,
   input logic            TDR_RESET,
   wrapper_chain_if.slave bus
);
   localparam int             CW       = $clog2(WIDTH + 2);
   localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0]  CNT_MAX  = CW'(WIDTH + 1);

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] ur;
   logic [WIDTH-1:0] cfo;
   logic [CW-1:0]    cnt;
   logic             upd_valid;
   logic             shift_cnt_err;
   logic             freeze;

   assign freeze = (bus.wrp_mode == 2'b11);

`ifdef WRAPCHAIN_BYPASS_EN
   logic byp;
   assign bus.WSO = bus.wrp_bypass ? byp : sr[0];
`else
   assign bus.WSO = sr[0];
`endif

   assign bus.CFO           = cfo;
   assign bus.upd_valid     = upd_valid;
   assign bus.shift_cnt_err = shift_cnt_err;

   always_ff @(posedge TDR_TCK) begin
      if (TDR_RESET) begin
         sr            <= '0;
         ur            <= SAFE_VAL;
         cfo           <= SAFE_VAL;
         cnt           <= '0;
         upd_valid     <= 1'b0;
         shift_cnt_err <= 1'b0;
`ifdef WRAPCHAIN_BYPASS_EN
         byp           <= 1'b0;
`endif
      end else begin
         case (bus.wrp_mode)
            2'b00:   cfo <= bus.CFI;
            2'b10:   cfo <= SAFE_VAL;
            default: cfo <= ur;
         endcase

         if (bus.TDR_EN) begin
`ifdef WRAPCHAIN_BYPASS_EN
            // In bypass the main chain, its counter and the update path all hold.
            if (bus.wrp_bypass) begin
               if (bus.TDR_CAPTURE)
                  byp <= 1'b0;
               else if (bus.TDR_SHIFT)
                  byp <= bus.WSI;
            end else
`endif
            begin
               if (bus.TDR_CAPTURE)
                  sr <= bus.CFI;
               else if (bus.TDR_SHIFT)
                  sr <= {bus.WSI, sr[WIDTH-1:1]};

               // Even a frozen update restarts the length count.
               if (bus.TDR_CAPTURE || bus.TDR_UPDATE)
                  cnt <= '0;
               else if (bus.TDR_SHIFT && cnt != CNT_MAX)
                  cnt <= cnt + CW'(1);

               if (bus.TDR_UPDATE && !freeze) begin
                  ur <= sr;
                  if (cnt == CNT_FULL) begin
                     upd_valid <= 1'b1;
                  end else begin
                     upd_valid     <= 1'b0;
                     shift_cnt_err <= 1'b1;
                  end
               end

               if (bus.TDR_CAPTURE)
                  upd_valid <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_wrapper_chain.sv
// tb/tb_wrapper_chain.sv - randomized self-checking bench for wrapper_chain (WIDTH=8, SAFE_VAL=8'hA5)
module tb_wrapper_chain;
   localparam int         W    = 8;
   localparam logic [7:0] SAFE = 8'hA5;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   wrapper_chain_if #(.WIDTH(W)) bus ();

   wrapper_chain #(.WIDTH(W), .SAFE_VAL(SAFE)) dut (
      .TDR_TCK   (clk),
      .TDR_RESET (rst),
      .bus       (bus)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic c, input logic s, input logic u, input logic w);
      bus.TDR_CAPTURE = c;
      bus.TDR_SHIFT   = s;
      bus.TDR_UPDATE  = u;
      bus.WSI         = w;
      tick();
      bus.TDR_CAPTURE = 1'b0;
      bus.TDR_SHIFT   = 1'b0;
      bus.TDR_UPDATE  = 1'b0;
      bus.WSI         = 1'b0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      bus.wrp_mode = 2'b10;
      rst = 1'b1;
      tick();
      tick();
      n_cmp++; if (bus.CFO !== SAFE) begin n_err++; $display("FAIL reset_cfo got=%h exp=%h", bus.CFO, SAFE); end
      n_cmp++; if (bus.WSO !== 1'b0) begin n_err++; $display("FAIL reset_wso got=%b exp=0", bus.WSO); end
      n_cmp++; if (bus.upd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.upd_valid); end
      n_cmp++; if (bus.shift_cnt_err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", bus.shift_cnt_err); end
      rst = 1'b0;
      tick();
      n_cmp++; if (bus.CFO !== SAFE) begin n_err++; $display("FAIL safe_cfo got=%h exp=%h", bus.CFO, SAFE); end
   endtask

   task automatic test_directed_load;
      logic [7:0] ew;
      logic [7:0] wi;
      ew = 8'h3C;
      wi = 8'hC3;
      bus.wrp_mode = 2'b01;
      bus.CFI      = 8'h3C;
      cyc(1, 0, 0, 0);
      for (int i = 0; i < W; i++) begin
         n_cmp++; if (bus.WSO !== ew[i]) begin n_err++; $display("FAIL dir_wso[%0d] got=%b exp=%b", i, bus.WSO, ew[i]); end
         cyc(0, 1, 0, wi[i]);
      end
      cyc(0, 0, 1, 0);
      n_cmp++; if (bus.upd_valid !== 1'b1) begin n_err++; $display("FAIL dir_valid got=%b exp=1", bus.upd_valid); end
      n_cmp++; if (bus.CFO !== SAFE) begin n_err++; $display("FAIL dir_cfo_early got=%h exp=%h", bus.CFO, SAFE); end
      tick();
      n_cmp++; if (bus.CFO !== 8'hC3) begin n_err++; $display("FAIL dir_cfo got=%h exp=c3", bus.CFO); end
   endtask

   task automatic test_short_shift;
      logic [63:0] stream;
      for (int pass = 0; pass < 2; pass++) begin
         int n;
         n = (pass == 0) ? 7 : 8;
         stream = {$urandom, $urandom};
         bus.CFI = stream[7:0];
         cyc(1, 0, 0, 0);
         for (int i = 0; i < n; i++) cyc(0, 1, 0, stream[8 + i]);
         cyc(0, 0, 1, 0);
         n_cmp++; if (bus.upd_valid !== (n == 8)) begin n_err++; $display("FAIL short_valid[%0d] got=%b exp=%b", n, bus.upd_valid, (n == 8)); end
         n_cmp++; if (bus.shift_cnt_err !== 1'b1) begin n_err++; $display("FAIL short_err[%0d] got=%b exp=1", n, bus.shift_cnt_err); end
         tick();
         n_cmp++; if (bus.CFO !== stream[n +: 8]) begin n_err++; $display("FAIL short_cfo[%0d] got=%h exp=%h", n, bus.CFO, stream[n +: 8]); end
      end
   endtask

   task automatic test_freeze;
      logic [7:0] wi;
      wi = 8'hC3;
      do_reset();
      bus.wrp_mode = 2'b01;
      bus.CFI      = 8'($urandom);
      cyc(1, 0, 0, 0);
      for (int i = 0; i < W; i++) cyc(0, 1, 0, wi[i]);
      cyc(0, 0, 1, 0);
      n_cmp++; if (bus.upd_valid !== 1'b1) begin n_err++; $display("FAIL frz_pre_valid got=%b exp=1", bus.upd_valid); end
      bus.wrp_mode = 2'b11;
      for (int i = 0; i < W; i++) cyc(0, 1, 0, 1'b1);
      n_cmp++; if (bus.WSO !== 1'b1) begin n_err++; $display("FAIL frz_wso got=%b exp=1", bus.WSO); end
      cyc(0, 0, 1, 0);
      n_cmp++; if (bus.upd_valid !== 1'b1) begin n_err++; $display("FAIL frz_valid got=%b exp=1", bus.upd_valid); end
      n_cmp++; if (bus.shift_cnt_err !== 1'b0) begin n_err++; $display("FAIL frz_err got=%b exp=0", bus.shift_cnt_err); end
      tick();
      n_cmp++; if (bus.CFO !== 8'hC3) begin n_err++; $display("FAIL frz_cfo got=%h exp=c3", bus.CFO); end
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1'b0);
      cyc(0, 0, 1, 0);
      n_cmp++; if (bus.shift_cnt_err !== 1'b0) begin n_err++; $display("FAIL frz_short_err got=%b exp=0", bus.shift_cnt_err); end
      n_cmp++; if (bus.upd_valid !== 1'b1) begin n_err++; $display("FAIL frz_short_valid got=%b exp=1", bus.upd_valid); end
      bus.wrp_mode = 2'b01;
      tick();
      n_cmp++; if (bus.CFO !== 8'hC3) begin n_err++; $display("FAIL frz_exit_cfo got=%h exp=c3", bus.CFO); end
   endtask

   task automatic test_capture_priority;
      bus.wrp_mode = 2'b01;
      bus.CFI      = 8'h81;
      cyc(1, 1, 0, 0);
      n_cmp++; if (bus.WSO !== 1'b1) begin n_err++; $display("FAIL prio_wso got=%b exp=1", bus.WSO); end
      for (int i = 0; i < W; i++) cyc(0, 1, 0, 1'($urandom));
      cyc(0, 0, 1, 0);
      n_cmp++; if (bus.upd_valid !== 1'b1) begin n_err++; $display("FAIL prio_valid got=%b exp=1", bus.upd_valid); end
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1'b1);
      cyc(0, 0, 1, 0);
      n_cmp++; if (bus.shift_cnt_err !== 1'b1) begin n_err++; $display("FAIL prio_err got=%b exp=1", bus.shift_cnt_err); end
      bus.CFI = 8'h81;
      cyc(1, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1'b1);
      rst = 1'b1;
      cyc(0, 1, 0, 1'b1);
      rst = 1'b0;
      n_cmp++; if (bus.CFO !== SAFE) begin n_err++; $display("FAIL rst_cfo got=%h exp=%h", bus.CFO, SAFE); end
      n_cmp++; if (bus.WSO !== 1'b0) begin n_err++; $display("FAIL rst_wso got=%b exp=0", bus.WSO); end
      n_cmp++; if (bus.upd_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", bus.upd_valid); end
      n_cmp++; if (bus.shift_cnt_err !== 1'b0) begin n_err++; $display("FAIL rst_err got=%b exp=0", bus.shift_cnt_err); end
      for (int i = 0; i < W; i++) cyc(0, 1, 0, 1'b0);
      cyc(0, 0, 1, 0);
      n_cmp++; if (bus.upd_valid !== 1'b1) begin n_err++; $display("FAIL rst_cnt_valid got=%b exp=1", bus.upd_valid); end
   endtask

   task automatic test_enable;
      logic [63:0] stream;
      do_reset();
      bus.wrp_mode = 2'b01;
      stream = {$urandom, $urandom};
      bus.CFI = stream[7:0];
      cyc(1, 0, 0, 0);
      for (int i = 0; i < W; i++) cyc(0, 1, 0, stream[8 + i]);
      cyc(0, 0, 1, 0);
      tick();
      bus.TDR_EN = 1'b0;
      bus.CFI    = ~stream[15:8];
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, ~stream[8]);
      cyc(0, 0, 1, 0);
      tick();
      n_cmp++; if (bus.upd_valid !== 1'b1) begin n_err++; $display("FAIL en_valid got=%b exp=1", bus.upd_valid); end
      n_cmp++; if (bus.WSO !== stream[8]) begin n_err++; $display("FAIL en_wso got=%b exp=%b", bus.WSO, stream[8]); end
      n_cmp++; if (bus.CFO !== stream[15:8]) begin n_err++; $display("FAIL en_cfo got=%h exp=%h", bus.CFO, stream[15:8]); end
      bus.TDR_EN = 1'b1;
   endtask

   task automatic test_functional;
      logic [7:0] v;
      bus.wrp_mode = 2'b00;
      for (int i = 0; i < 16; i++) begin
         v = 8'($urandom);
         bus.CFI = v;
         tick();
         n_cmp++; if (bus.CFO !== v) begin n_err++; $display("FAIL func_cfo[%0d] got=%h exp=%h", i, bus.CFO, v); end
      end
      bus.wrp_mode = 2'b10;
      tick();
      n_cmp++; if (bus.CFO !== SAFE) begin n_err++; $display("FAIL func_safe got=%h exp=%h", bus.CFO, SAFE); end
   endtask

   task automatic test_random_loads;
      logic [63:0] stream;
      logic        m_err;
      int          n;
      do_reset();
      m_err = 1'b0;
      for (int it = 0; it < 30; it++) begin
         bus.wrp_mode = 2'($urandom_range(0, 2));
         n = ($urandom_range(0, 5) == 0) ? 24 : $urandom_range(5, 10);
         stream = {$urandom, $urandom};
         bus.CFI = stream[7:0];
         cyc(1, 0, 0, 0);
         for (int i = 0; i < n; i++) begin
            n_cmp++; if (bus.WSO !== stream[i]) begin n_err++; $display("FAIL rnd_wso[%0d/%0d] got=%b exp=%b", it, i, bus.WSO, stream[i]); end
            cyc(0, 1, 0, stream[8 + i]);
         end
         cyc(0, 0, 1, 0);
         m_err = m_err | (n != W);
         n_cmp++; if (bus.upd_valid !== (n == W)) begin n_err++; $display("FAIL rnd_valid[%0d] n=%0d got=%b exp=%b", it, n, bus.upd_valid, (n == W)); end
         n_cmp++; if (bus.shift_cnt_err !== m_err) begin n_err++; $display("FAIL rnd_err[%0d] got=%b exp=%b", it, bus.shift_cnt_err, m_err); end
         bus.wrp_mode = 2'b01;
         tick();
         n_cmp++; if (bus.CFO !== stream[n +: 8]) begin n_err++; $display("FAIL rnd_cfo[%0d] got=%h exp=%h", it, bus.CFO, stream[n +: 8]); end
      end
   endtask

`ifdef WRAPCHAIN_BYPASS_EN
   task automatic test_bypass;
      logic [2:0] pat;
      logic [7:0] v;
      pat = 3'b101;
      v   = 8'($urandom) | 8'h01;
      do_reset();
      bus.wrp_mode = 2'b01;
      bus.CFI      = v;
      cyc(1, 0, 0, 0);
      bus.wrp_bypass = 1'b1;
      for (int i = 2; i >= 0; i--) begin
         cyc(0, 1, 0, pat[i]);
         n_cmp++; if (bus.WSO !== pat[i]) begin n_err++; $display("FAIL byp_wso[%0d] got=%b exp=%b", i, bus.WSO, pat[i]); end
      end
      cyc(0, 0, 1, 0);
      n_cmp++; if (bus.upd_valid !== 1'b0) begin n_err++; $display("FAIL byp_upd_valid got=%b exp=0", bus.upd_valid); end
      bus.wrp_bypass = 1'b0;
      tick();
      n_cmp++; if (bus.WSO !== v[0]) begin n_err++; $display("FAIL byp_sr_hold got=%b exp=%b", bus.WSO, v[0]); end
      for (int i = 0; i < W; i++) cyc(0, 1, 0, 1'b0);
      cyc(0, 0, 1, 0);
      n_cmp++; if (bus.upd_valid !== 1'b1) begin n_err++; $display("FAIL byp_cnt_hold got=%b exp=1", bus.upd_valid); end
   endtask
`endif

   initial begin
      rst             = 1'b1;
      bus.TDR_EN      = 1'b1;
      bus.TDR_CAPTURE = 1'b0;
      bus.TDR_SHIFT   = 1'b0;
      bus.TDR_UPDATE  = 1'b0;
      bus.wrp_mode    = 2'b10;
      bus.WSI         = 1'b0;
      bus.CFI         = '0;
`ifdef WRAPCHAIN_BYPASS_EN
      bus.wrp_bypass  = 1'b0;
`endif
      test_reset();
      test_directed_load();
      test_short_shift();
      test_freeze();
      test_capture_priority();
      test_enable();
      test_functional();
      test_random_loads();
`ifdef WRAPCHAIN_BYPASS_EN
      test_bypass();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
